// File: rtl/bridge_bus2ram.sv
// Bus slave that bridges a read/write command channel onto a single-port RAM, with up to two responses in flight.
// Define BRIDGE_BUS2RAM_WRITE_RESP_EN for non-posted writes; without it, writes are posted and produce no response.
module bridge_bus2ram #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    // bus slave side
    input  logic                    bus_mreset_n_i,
    input  logic [2:0]              bus_mcmd_i,
    input  logic [ADDR_WIDTH-1:0]   bus_maddr_i,
    input  logic [DATA_WIDTH-1:0]   bus_mdata_i,
    input  logic [DATA_WIDTH/8-1:0] bus_mbyteen_i,
    input  logic                    bus_mrespaccept_i,
    output logic                    bus_scmdaccept_o,
    output logic [1:0]              bus_sresp_o,
    output logic [DATA_WIDTH-1:0]   bus_sdata_o,
    // ram client side
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_data_w_o,
    input  logic [DATA_WIDTH-1:0]   ram_data_r_i,
    input  logic                    ram_delay_i
);

    localparam logic [2:0] CMD_WR    = 3'd1;
    localparam logic [2:0] CMD_RD    = 3'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;
`ifdef BRIDGE_BUS2RAM_WRITE_RESP_EN
    localparam bit WRITE_RESP = 1'b1;
`else
    localparam bit WRITE_RESP = 1'b0;
`endif

    logic                  pending_q, pending_d;
    logic                  pending_wr_q, pending_wr_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [DATA_WIDTH-1:0] fifo_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;

    logic                  flush, is_rd, is_wr, valid_cmd, needs_credit;
    logic                  credit_ok, fwd, accept;
    logic                  fifo_empty, head_valid, pop, fifo_pop, push;
    logic [1:0]            outstanding;
    logic [DATA_WIDTH-1:0] pend_word;

    // Command decode, credit and RAM forwarding; credit uses registered state only.
    always_comb begin
        flush        = !bus_mreset_n_i || !reset_n;
        is_rd        = (bus_mcmd_i == CMD_RD);
        is_wr        = (bus_mcmd_i == CMD_WR);
        valid_cmd    = is_rd || is_wr;
        needs_credit = is_rd || WRITE_RESP;
        outstanding  = 2'({1'b0, pending_q}) + cnt_q;
        credit_ok    = (outstanding < 2'd2);
        fwd          = valid_cmd && !flush && (credit_ok || !needs_credit);
        accept       = fwd && !ram_delay_i;
    end

    assign bus_scmdaccept_o = accept;
    assign ram_en_o         = fwd;
    assign ram_we_o         = fwd && is_wr;
    assign ram_addr_o       = bus_maddr_i;
    assign ram_be_o         = bus_mbyteen_i;
    assign ram_data_w_o     = bus_mdata_i;

    // Response head: FIFO first, else the word returning from RAM this cycle.
    always_comb begin
        pend_word  = pending_wr_q ? '0 : ram_data_r_i;
        fifo_empty = (cnt_q == 2'd0);
        head_valid = !fifo_empty || pending_q;
        pop        = head_valid && bus_mrespaccept_i;
        fifo_pop   = pop && !fifo_empty;
        push       = pending_q && !(fifo_empty && pop);
        if (!fifo_empty) begin
            bus_sdata_o = fifo_q[rd_ptr_q];
        end else if (pending_q) begin
            bus_sdata_o = pend_word;
        end else begin
            bus_sdata_o = '0;
        end
    end

    assign bus_sresp_o = head_valid ? RESP_DVA : RESP_NULL;

    // Next-state for pending flag and response FIFO.
    always_comb begin
        pending_d    = accept && needs_credit;
        pending_wr_d = accept && is_wr && WRITE_RESP;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q + 2'(push) - 2'(fifo_pop);
        if (push) begin
            fifo_d[wr_ptr_q] = pend_word;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (fifo_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (flush) begin
            pending_d    = 1'b0;
            pending_wr_d = 1'b0;
            wr_ptr_d     = 1'b0;
            rd_ptr_d     = 1'b0;
            cnt_d        = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q    <= 1'b0;
            pending_wr_q <= 1'b0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= 2'd0;
        end else begin
            pending_q    <= pending_d;
            pending_wr_q <= pending_wr_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bridge_bus2ram.sv
// Scoreboard bench for bridge_bus2ram: directed commands push expected responses, a monitor pops and compares.
module tb_bridge_bus2ram;

    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_WR    = 3'd1;
    localparam logic [2:0] CMD_RD    = 3'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bus_mreset_n;
    logic [2:0]  bus_mcmd;
    logic [31:0] bus_maddr;
    logic [31:0] bus_mdata;
    logic [3:0]  bus_mbyteen;
    logic        bus_mrespaccept;
    logic        bus_scmdaccept;
    logic [1:0]  bus_sresp;
    logic [31:0] bus_sdata;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_data_w;
    logic [31:0] ram_data_r;
    logic        ram_delay;
    logic        mem_load;

    logic [31:0] mem [256];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bridge_bus2ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .bus_mreset_n_i    (bus_mreset_n),
        .bus_mcmd_i        (bus_mcmd),
        .bus_maddr_i       (bus_maddr),
        .bus_mdata_i       (bus_mdata),
        .bus_mbyteen_i     (bus_mbyteen),
        .bus_mrespaccept_i (bus_mrespaccept),
        .bus_scmdaccept_o  (bus_scmdaccept),
        .bus_sresp_o       (bus_sresp),
        .bus_sdata_o       (bus_sdata),
        .ram_en_o          (ram_en),
        .ram_we_o          (ram_we),
        .ram_addr_o        (ram_addr),
        .ram_be_o          (ram_be),
        .ram_data_w_o      (ram_data_w),
        .ram_data_r_i      (ram_data_r),
        .ram_delay_i       (ram_delay)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i < 8)                  return 32'(i * 3);
        if (i < 12)                 return 32'h100 + 32'(i);
        if (i == 'h10)              return 32'hDEADBEEF;
        if (i == 'h20)              return 32'h55AA1234;
        if (i == 'h30 || i == 'h31) return 32'h30000000 + 32'(i);
        if (i == 'h40)              return 32'hCAFEF00D;
        if (i == 'h41)              return 32'h0BADC0DE;
        return 32'hA5000000 + 32'(i);
    endfunction

    // RAM model: one-cycle read latency, byte-enabled writes, stalls while delay is high.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            ram_data_r <= '0;
        end else if (ram_en && !ram_delay) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_data_w[8*b +: 8];
            end else begin
                ram_data_r <= mem[ram_addr[7:0]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every delivered response is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (bus_sresp == RESP_DVA && bus_mrespaccept) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got data %h expected no response", bus_sdata);
            end else begin
                check("resp_data", bus_sdata, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [2:0] cmd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        bus_mcmd    = cmd;
        bus_maddr   = addr;
        bus_mdata   = data;
        bus_mbyteen = be;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a command, wait (bounded) for accept, push its expected response.
    task automatic do_cmd(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input bit has_resp, input logic [31:0] exp_data,
                          input int budget, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        drive(cmd, addr, data, be);
        while (!done) begin
            @(negedge clk);
            if (bus_scmdaccept) begin
                done = 1'b1;
                if (has_resp) exp_q.push_back(exp_data);
                check("ram_we_at_accept", 32'(ram_we), 32'(cmd == CMD_WR));
            end else begin
                waits++;
                if (waits > budget) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: got no accept after %0d cycles expected within %0d", waits, budget);
                    done = 1'b1;
                end
            end
        end
        step();
    endtask

    initial begin
        int w;
        reset_n         = 1'b0;
        mem_load        = 1'b1;
        bus_mreset_n    = 1'b1;
        bus_mrespaccept = 1'b1;
        ram_delay       = 1'b0;
        drive(CMD_RD, 32'h10, '0, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sresp", 32'(bus_sresp), 32'(RESP_NULL));
        check("rst_sdata", bus_sdata, 32'h0);
        check("rst_accept", 32'(bus_scmdaccept), 32'h0);
        check("rst_ram_en", 32'(ram_en), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        drive(CMD_IDLE, '0, '0, '0);
        step();
        mem_load = 1'b0;
        reset_n  = 1'b1;
        step();

        // Single read: accept cycle 0, DVA cycle 1, NULL cycle 2.
        do_cmd(CMD_RD, 32'h10, '0, 4'hF, 1'b1, 32'hDEADBEEF, 0, w);
        check("rd_first_try", 32'(w), 32'h0);
        drive(CMD_IDLE, '0, '0, '0);
        @(negedge clk);
        check("rd_latency_dva", 32'(bus_sresp), 32'(RESP_DVA));
        step();
        @(negedge clk);
        check("rd_after_null", 32'(bus_sresp), 32'(RESP_NULL));
        step();

        // Eight back-to-back reads must each be accepted at once.
        for (int i = 0; i < 8; i++) begin
            do_cmd(CMD_RD, 32'(i), '0, 4'hF, 1'b1, 32'(i * 3), 0, w);
            check("stream_accept", 32'(w), 32'h0);
        end
        drive(CMD_IDLE, '0, '0, '0);
        repeat (3) step();

        // Backpressure: two accepts, then held DVA and no accept for four more cycles.
        bus_mrespaccept = 1'b0;
        do_cmd(CMD_RD, 32'h8, '0, 4'hF, 1'b1, 32'h108, 0, w);
        do_cmd(CMD_RD, 32'h9, '0, 4'hF, 1'b1, 32'h109, 0, w);
        drive(CMD_RD, 32'hA, '0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_no_accept", 32'(bus_scmdaccept), 32'h0);
            check("bp_held_resp", 32'(bus_sresp), 32'(RESP_DVA));
            check("bp_held_data", bus_sdata, 32'h108);
            step();
        end
        bus_mrespaccept = 1'b1;
        do_cmd(CMD_RD, 32'hA, '0, 4'hF, 1'b1, 32'h10A, 3, w);
        check("bp_release_wait", 32'(w), 32'h1);
        do_cmd(CMD_RD, 32'hB, '0, 4'hF, 1'b1, 32'h10B, 3, w);
        drive(CMD_IDLE, '0, '0, '0);
        repeat (4) step();

        // Write then read of the same word, partial byte enables.
`ifdef BRIDGE_BUS2RAM_WRITE_RESP_EN
        do_cmd(CMD_WR, 32'h4, 32'h12345678, 4'b0011, 1'b1, 32'h0, 0, w);
`else
        do_cmd(CMD_WR, 32'h4, 32'h12345678, 4'b0011, 1'b0, 32'h0, 0, w);
`endif
        do_cmd(CMD_RD, 32'h4, '0, 4'hF, 1'b1, 32'h00005678, 0, w);
        drive(CMD_IDLE, '0, '0, '0);
        repeat (3) step();

        // RAM stall: request held with stable fields for three cycles.
        ram_delay = 1'b1;
        drive(CMD_RD, 32'h20, '0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_en", 32'(ram_en), 32'h1);
            check("stall_addr", ram_addr, 32'h20);
            check("stall_no_accept", 32'(bus_scmdaccept), 32'h0);
            step();
        end
        ram_delay = 1'b0;
        do_cmd(CMD_RD, 32'h20, '0, 4'hF, 1'b1, 32'h55AA1234, 0, w);
        check("stall_accept_4th", 32'(w), 32'h0);
        drive(CMD_IDLE, '0, '0, '0);
        @(negedge clk);
        check("stall_dva_5th", 32'(bus_sresp), 32'(RESP_DVA));
        repeat (3) step();

        // Async reset with two responses outstanding.
        bus_mrespaccept = 1'b0;
        do_cmd(CMD_RD, 32'h30, '0, 4'hF, 1'b1, 32'h30000030, 0, w);
        do_cmd(CMD_RD, 32'h31, '0, 4'hF, 1'b1, 32'h30000031, 0, w);
        drive(CMD_IDLE, '0, '0, '0);
        reset_n = 1'b0;
        exp_q.delete();
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("rstn_flush_null", 32'(bus_sresp), 32'(RESP_NULL));
        step();
        bus_mrespaccept = 1'b1;
        do_cmd(CMD_RD, 32'h40, '0, 4'hF, 1'b1, 32'hCAFEF00D, 0, w);
        check("rstn_first_accept", 32'(w), 32'h0);
        drive(CMD_IDLE, '0, '0, '0);
        repeat (3) step();

        // Synchronous bus flush with two responses outstanding.
        bus_mrespaccept = 1'b0;
        do_cmd(CMD_RD, 32'h30, '0, 4'hF, 1'b1, 32'h30000030, 0, w);
        do_cmd(CMD_RD, 32'h31, '0, 4'hF, 1'b1, 32'h30000031, 0, w);
        bus_mreset_n = 1'b0;
        drive(CMD_RD, 32'h41, '0, 4'hF);
        @(negedge clk);
        check("flush_no_accept", 32'(bus_scmdaccept), 32'h0);
        check("flush_no_ram_en", 32'(ram_en), 32'h0);
        exp_q.delete();
        step();
        bus_mreset_n = 1'b1;
        drive(CMD_IDLE, '0, '0, '0);
        @(negedge clk);
        check("flush_null", 32'(bus_sresp), 32'(RESP_NULL));
        step();
        bus_mrespaccept = 1'b1;
        do_cmd(CMD_RD, 32'h41, '0, 4'hF, 1'b1, 32'h0BADC0DE, 0, w);
        drive(CMD_IDLE, '0, '0, '0);
        repeat (5) step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time %0t expected earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bridge_bus2ram.md
# bridge_bus2ram

Bus slave that terminates a `Bus_if` read/write channel and drives a single-port memory through `Ram_if`. It is the responder end of the bus protocol: a bus master, such as an instruction-fetch bridge or DMA, reaches a local RAM through this block. Up to two responses can be in flight, so the master can stream one access per cycle while `MRespAccept` stays high. RAM stall (`delay`) and response backpressure (`MRespAccept`) are both honoured without losing data.

## Interface
- `ADDR_WIDTH`, default 32, address width forwarded to RAM.
- `DATA_WIDTH`, default 32, data width; byte-enable width is `DATA_WIDTH/8`.
- `clk`  in  1  single clock, all state on rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `bus`  `Bus_if.slave`  –  uses the following signals:
  - in: `MReset_n`, `MCmd`, `MAddr[ADDR_WIDTH]`, `MData[DATA_WIDTH]`, `MByteEn`, `MRespAccept`.
  - out: `SCmdAccept`, `SResp`, `SData[DATA_WIDTH]`.
- `ram`  `Ram_if.client`  –  uses the following signals:
  - out: `en`, `we`, `addr`, `be`, `data_w`.
  - in: `data_r`, `delay`.

## Operation
- **Command decode:**
  - `MCmd=Bus::RD` is a read; `Bus::WR` is a write.
  - Every other code is treated as `Bus::IDLE`.
- **Forwarding to RAM:**
  - A valid command is forwarded combinationally while `credit_ok`: `ram.en=1`, `ram.we=(MCmd==WR)`, `ram.addr=MAddr`, `ram.be=MByteEn`, `ram.data_w=MData`.
  - `ram.en=0` whenever `!credit_ok`.
- **Accept:** `SCmdAccept = valid_cmd && credit_ok && !ram.delay`. A command is taken exactly in a cycle with `SCmdAccept=1`.
- **Outstanding count** = `pending` (1 bit) + `fifo_count` (0..2). `credit_ok` = outstanding < 2.
- **pending:**
  - Set on an accepted command that produces a response; otherwise cleared each cycle.
  - The cycle after acceptance, `ram.data_r` is valid (or zero data for a write response).
- **Response path:**
  - 2-entry FIFO of `DATA_WIDTH` words.
  - Head selection, in priority order:
    - if the FIFO is non-empty, `SResp=DVA`, `SData=fifo_head`;
    - else if `pending`, `SResp=DVA` and `SData` is bypassed from `ram.data_r` (reads) or `'0` (writes);
    - else `SResp=Bus::NULL`, `SData='0`.
  - Pop or consume the head when `SResp==DVA && MRespAccept`.
  - A `pending` word that is not consumed via bypass is pushed into the FIFO.
  - Simultaneous push and pop is allowed.
- **Ordering:** responses are returned strictly in command order.
- **Flush:** `bus.MReset_n=0` is a synchronous flush.
  - Clears `pending` and the FIFO.
  - Forces `SCmdAccept=0` and `ram.en=0` in that cycle.

## Timing
- **Reset values (`reset_n=0`):** `pending=0`, FIFO empty, `SResp=NULL`, `SData=0`, `SCmdAccept=0`, `ram.en=0`, `ram.we=0`.
- **Read latency:** accept in cycle N gives `SResp=DVA` in N+1 with data bypassed from RAM, provided the FIFO is empty.
- **Throughput:** with `MRespAccept=1` held, one access per cycle sustained; outstanding never exceeds 1.
- **Backpressure:**
  - With `MRespAccept=0`, the block accepts at most 2 unanswered commands.
  - `SCmdAccept` stays 0 until a pop frees credit.
  - Credit is computed from registered state only; there is no combinational path from `MRespAccept` to `SCmdAccept`.
- **RAM stall:**
  - While `ram.delay=1`, `ram.en` stays asserted with the same fields and `SCmdAccept=0`.
  - The access completes in the first cycle with `delay=0`.
- **Held response:** `SResp` and `SData` stay stable while `DVA` is presented and `MRespAccept=0`.
- **Reset mid-operation:** all in-flight responses are discarded; after reset deassertion the first accept is possible in the first cycle.

## Configuration
- **`BRIDGE_BUS2RAM_WRITE_RESP_EN`** defined (non-posted writes):
  - Each accepted write sets `pending` and yields one `SResp=DVA` with `SData=0`, in order with reads.
  - Writes consume credit.
- **Macro undefined (posted writes):**
  - Writes never set `pending` and produce no response.
  - Writes consume no credit; they are accepted whenever `!ram.delay` and not flushing.
  - They still respect ordering with respect to RAM: a write is issued in its accept cycle.

## Test plan
- RD `0x10`, RAM returns `0xDEADBEEF`, `MRespAccept=1` → `SCmdAccept=1` in cycle 0, `SResp=DVA` with `SData=0xDEADBEEF` in cycle 1, `NULL` in cycle 2.
- 8 back-to-back RDs at addresses 0..7 with `data_r=addr*3`, `MRespAccept=1` → 8 consecutive accepts, then `DVA` in cycles 1..8 with data 0,3,…,21.
- 4 RDs with `MRespAccept=0` for 6 cycles → exactly 2 accepts and `SCmdAccept=0` thereafter, `DVA` held with the first word; on release the data is drained in order and the remaining 2 reads are accepted.
- WR `0x4`/`0x12345678` with `be=0b0011` followed by a RD of `0x4` → RAM sees `we=1` then `we=0`. With the macro: `DVA` (data 0) then `DVA` with the read data. Without the macro: a single `DVA`.
- `ram.delay=1` for 3 cycles during a RD → `ram.en` held with stable fields and `SCmdAccept=0` for 3 cycles, accept in the 4th cycle, `DVA` in the 5th.
- `reset_n` pulsed low, and separately `MReset_n` pulsed low, with 2 responses outstanding → `SResp=NULL` the next cycle, no stale data delivered, and a new RD answered normally.
